// File: rtl/tag_directory_pkg.sv
// ============================================================================
// Module      : tag_directory_pkg
// Description : Shared types and helpers for the set-associative tag directory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_directory_pkg;

   typedef struct packed {
      logic valid;
      logic dirty;
   } tag_status_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   function automatic int unsigned depth_of(input int unsigned index_width);
      return 32'd1 << index_width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tag_directory_tag_bank.sv
// ============================================================================
// Module      : tag_bank
// Description : One way's tag RAM; write/read port A, read-only port B, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_bank
   import tag_directory_pkg::*;
#(
   parameter int TAG_SIZE    = 20,
   parameter int INDEX_WIDTH = 6
) (
   input  logic                   clk_i,
   input  logic [INDEX_WIDTH-1:0] a_index_i,
   input  logic                   a_write_i,
   input  logic [TAG_SIZE-1:0]    a_tag_i,
   input  logic                   a_read_i,
   output logic [TAG_SIZE-1:0]    a_tag_o,
   input  logic                   b_read_i,
   input  logic [INDEX_WIDTH-1:0] b_index_i,
   output logic [TAG_SIZE-1:0]    b_tag_o
);

   localparam int unsigned c_depth = depth_of(INDEX_WIDTH);

   logic [TAG_SIZE-1:0] r_mem [c_depth];
   logic [TAG_SIZE-1:0] r_a_q;
   logic [TAG_SIZE-1:0] r_b_q;

   // A write suppresses the port A read; the read register then holds.
   always_ff @(posedge clk_i) begin
      if (a_write_i) begin
         r_mem[a_index_i] <= a_tag_i;
      end else if (a_read_i) begin
         r_a_q <= r_mem[a_index_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (b_read_i) begin
         r_b_q <= r_mem[b_index_i];
      end
   end

   assign a_tag_o = r_a_q;
   assign b_tag_o = r_b_q;

endmodule

`default_nettype wire

// File: rtl/tag_directory.sv
// ============================================================================
// Module      : tag_directory
// Description : WAYS-way tag directory with status flops, invalidate sweep,
//               write-first port B forwarding and registered hit compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_directory
   import tag_directory_pkg::*;
#(
   parameter int WAYS        = 2,
   parameter int INDEX_WIDTH = 6,
   parameter int TAG_SIZE    = 20
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   output logic                       busy_o,
   input  logic [INDEX_WIDTH-1:0]     a_index_i,
   input  logic [WAYS-1:0]            a_write_i,
   input  logic [TAG_SIZE-1:0]        a_tag_i,
   input  logic                       a_valid_i,
   input  logic                       a_dirty_i,
   input  logic                       a_read_i,
   input  logic [TAG_SIZE-1:0]        a_compare_i,
   output logic [WAYS*TAG_SIZE-1:0]   a_tag_o,
   output logic [WAYS-1:0]            a_valid_o,
   output logic [WAYS-1:0]            a_dirty_o,
   output logic [WAYS-1:0]            a_hit_o,
   input  logic                       b_read_i,
   input  logic [INDEX_WIDTH-1:0]     b_index_i,
   input  logic [TAG_SIZE-1:0]        b_compare_i,
   output logic [WAYS*TAG_SIZE-1:0]   b_tag_o,
   output logic [WAYS-1:0]            b_valid_o,
   output logic [WAYS-1:0]            b_hit_o
);

   localparam int unsigned            c_depth      = depth_of(INDEX_WIDTH);
   localparam logic [INDEX_WIDTH-1:0] c_last_index = '1;

   sweep_state_t           r_state;
   logic [INDEX_WIDTH-1:0] r_cnt;
   logic                   r_busy;

   tag_status_t            r_status [WAYS][c_depth];

   logic                   r_a_loaded;
   logic [TAG_SIZE-1:0]    r_a_cmp;
   tag_status_t            r_a_stat [WAYS];

   logic                   r_b_loaded;
   logic [TAG_SIZE-1:0]    r_b_cmp;
   logic [WAYS-1:0]        r_b_valid;
   logic [WAYS-1:0]        r_b_fwd;
   logic [TAG_SIZE-1:0]    r_b_fwd_tag;

   logic [WAYS-1:0]        w_we;
   logic [WAYS-1:0]        w_b_fwd;
   logic                   w_a_rd;
   logic                   w_b_rd;
   logic [TAG_SIZE-1:0]    w_bank_a [WAYS];
   logic [TAG_SIZE-1:0]    w_bank_b [WAYS];
   logic [TAG_SIZE-1:0]    w_a_tag  [WAYS];
   logic [TAG_SIZE-1:0]    w_b_tag  [WAYS];

   assign busy_o  = r_busy;
   assign w_we    = a_write_i & {WAYS{~r_busy}};
   assign w_a_rd  = a_read_i & ~r_busy & ~(|a_write_i);
   assign w_b_rd  = b_read_i & ~r_busy;
   assign w_b_fwd = w_we & {WAYS{a_index_i == b_index_i}};

   // Reset may land mid-sweep; it always restarts the sweep from index 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= SWEEP;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (flush_i) begin
                  r_state <= SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SWEEP: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_index) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Sweep clears and port A writes never overlap: writes are gated by busy.
   always_ff @(posedge clk_i) begin
      if (r_state == SWEEP) begin
         for (int w = 0; w < WAYS; w++) begin
            r_status[w][r_cnt] <= '0;
         end
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            if (w_we[w]) begin
               r_status[w][a_index_i] <= '{valid: a_valid_i, dirty: a_dirty_i};
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_a_loaded  <= 1'b0;
         r_a_cmp     <= '0;
         r_b_loaded  <= 1'b0;
         r_b_cmp     <= '0;
         r_b_valid   <= '0;
         r_b_fwd     <= '0;
         r_b_fwd_tag <= '0;
         for (int w = 0; w < WAYS; w++) begin
            r_a_stat[w] <= '0;
         end
      end else begin
         if (w_a_rd) begin
            r_a_loaded <= 1'b1;
            r_a_cmp    <= a_compare_i;
            for (int w = 0; w < WAYS; w++) begin
               r_a_stat[w] <= r_status[w][a_index_i];
            end
         end
         if (w_b_rd) begin
            r_b_loaded  <= 1'b1;
            r_b_cmp     <= b_compare_i;
            r_b_fwd     <= w_b_fwd;
            r_b_fwd_tag <= a_tag_i;
            for (int w = 0; w < WAYS; w++) begin
               r_b_valid[w] <= w_b_fwd[w] ? a_valid_i : r_status[w][b_index_i].valid;
            end
         end
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      tag_bank #(
         .TAG_SIZE    (TAG_SIZE),
         .INDEX_WIDTH (INDEX_WIDTH)
      ) u_bank (
         .clk_i     (clk_i),
         .a_index_i (a_index_i),
         .a_write_i (w_we[w]),
         .a_tag_i   (a_tag_i),
         .a_read_i  (w_a_rd),
         .a_tag_o   (w_bank_a[w]),
         .b_read_i  (w_b_rd),
         .b_index_i (b_index_i),
         .b_tag_o   (w_bank_b[w])
      );

      // The RAM has no reset, so tags read as zero until the first lookup.
      assign w_a_tag[w] = r_a_loaded ? w_bank_a[w] : '0;
      assign w_b_tag[w] = !r_b_loaded ? '0 : (r_b_fwd[w] ? r_b_fwd_tag : w_bank_b[w]);

      assign a_tag_o[w*TAG_SIZE +: TAG_SIZE] = w_a_tag[w];
      assign b_tag_o[w*TAG_SIZE +: TAG_SIZE] = w_b_tag[w];
      assign a_valid_o[w] = r_a_stat[w].valid;
      assign a_dirty_o[w] = r_a_stat[w].dirty;
      assign b_valid_o[w] = r_b_valid[w];
      assign a_hit_o[w]   = r_a_stat[w].valid && (w_a_tag[w] == r_a_cmp);
      assign b_hit_o[w]   = r_b_valid[w] && (w_b_tag[w] == r_b_cmp);
   end

endmodule

`default_nettype wire

// File: doc/tag_directory.md
# tag_directory

Set-associative tag directory for the L1 caches: per-way tag storage plus per-entry valid and dirty status, with one read/write port for the cache controller and one independent read-only lookup port for the pipeline. It generalises the single-way tag store to `WAYS` ways and registers a hit vector against a supplied compare tag. It adds write-first forwarding on index collisions and a sequential invalidate sweep after reset or flush. It sits between the cache controller FSM and the data memory banks.

## Interface
- `WAYS`, 2: number of ways; must be ≥1.
- `INDEX_WIDTH`, 6: set index width; depth = 2**INDEX_WIDTH sets.
- `TAG_SIZE`, 20: tag width in bits.

Ports:
- `clk_i`  in  1  single clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high; starts an invalidate sweep.
- `flush_i`  in  1  request invalidate-all sweep.
- `busy_o`  out  1  high while a sweep is in progress.
- `a_index_i`  in  INDEX_WIDTH  port A set index (read and write).
- `a_write_i`  in  WAYS  per-way write enable (normally one-hot).
- `a_tag_i`  in  TAG_SIZE  tag written to enabled ways.
- `a_valid_i`, `a_dirty_i`  in  1 each  status written with the tag.
- `a_read_i`  in  1  port A read request.
- `a_compare_i`  in  TAG_SIZE  port A compare tag, captured with the read.
- `a_tag_o`  out  WAYS×TAG_SIZE  registered tags.
- `a_valid_o`, `a_dirty_o`  out  WAYS each  registered status.
- `a_hit_o`  out  WAYS  per-way hit.
- `b_read_i`, `b_index_i`, `b_compare_i`  in  1 / INDEX_WIDTH / TAG_SIZE  port B lookup.
- `b_tag_o`, `b_valid_o`, `b_hit_o`  out  WAYS×TAG_SIZE / WAYS / WAYS  port B results.

## Operation
- Tags are held in RAM with no reset. Valid and dirty bits are held in flops, WAYS×depth each.
- Read: on an edge with the read request high and `busy_o` low, the port registers tag and status for all ways at the index and registers the compare tag. Otherwise the port's output registers hold their values.
- Hit: `hit[w] = valid_q[w] && (tag_q[w] == compare_q)`. It is combinational from the registered values only.
- Write: every way w with `a_write_i[w]` set stores `a_tag_i`, `a_valid_i` and `a_dirty_i` at `a_index_i`. Writes are ignored while `busy_o` is high.
- Port A write and `a_read_i` in the same cycle: the write wins and port A outputs hold their previous values.
- Port A write and port B read at the same index in the same cycle: write-first. Written ways return the new tag and status on port B; unwritten ways return stored contents.
- FSM states: `IDLE`, `SWEEP`.
  - `rst_i` moves to `SWEEP` from any state with counter = 0, including mid-sweep.
  - `flush_i` in `IDLE` moves to `SWEEP` with counter = 0.
  - `flush_i` in `SWEEP` is ignored; the sweep does not restart.
  - In `SWEEP`, each cycle clears valid and dirty for all ways at index = counter, then increments the counter.
  - After clearing index 2**INDEX_WIDTH−1, the FSM moves to `IDLE`; the counter wraps to 0.
- `busy_o = (state == SWEEP)`.
- Reset values: all `*_tag_o`, `*_valid_o`, `*_dirty_o`, `*_hit_o` are 0, compare registers are 0, and `busy_o` is 1 from the edge after `rst_i` is sampled.

## Timing
- Read latency: 1 cycle, request at edge N, data and hit valid after edge N.
- Write is visible to a port A read issued in the next cycle; same-cycle visibility exists on port B only.
- Sweep duration: exactly 2**INDEX_WIDTH cycles of `busy_o` high. The first request is accepted on the edge after `busy_o` falls.
- No backpressure: requests arriving while `busy_o` is high are dropped, and the controller gates them.

## Structure
- Shared cache package provides:
  - `tag_status_t`, a packed struct {valid, dirty};
  - `sweep_state_t`, an enum {IDLE, SWEEP};
  - a function returning depth from INDEX_WIDTH.
- Sub-module `tag_bank` holds one way's tag RAM: 1 write/read port, 1 read port, synchronous, no reset, TAG_SIZE × depth. It is instantiated WAYS times.
- Status flops, sweep FSM, collision forwarding and hit compare live in the top level.

## Test plan
- Reset sweep (WAYS=2, INDEX_WIDTH=6): pulse `rst_i` → `busy_o` high exactly 64 cycles, then a read of any index returns `valid_o=2'b00`, `hit_o=2'b00`.
- Write/read: write tag `0x12345` to way 1 at index 5 with valid=1, dirty=1, then port A read at index 5 with compare `0x12345` → `a_hit_o=2'b10`, `a_dirty_o[1]=1`.
- Collision: in the same cycle, port A writes `0x0ABCD` to way 0 at index 9 and port B reads index 9 → next cycle `b_tag_o[0]=0x0ABCD`, `b_valid_o[0]=1`.
- Write priority: `a_write_i` and `a_read_i` together → port A outputs unchanged from the prior cycle.
- Flush: valid entries at indices 0 and 63, pulse `flush_i`; a second `flush_i` at sweep cycle 10 still gives 64 busy cycles total, and both entries then miss.
- Reset mid-sweep: assert `rst_i` at sweep cycle 30 → `busy_o` stays high for 64 further cycles.
